// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and bit-period helpers.
// Imported by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_e;

  function automatic int baud_cnt_max(
    input int clk_freq,
    input int bps
  );
    return clk_freq / bps;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered dout and registered full/empty flags.
// Pointers carry one wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      lvl_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;
  assign wptr_d  = wptr_q + (AW+1)'(do_push);
  assign rptr_d  = rptr_q + (AW+1)'(do_pop);
  assign lvl_d   = wptr_d - rptr_d;

  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= (lvl_d == LVL_FULL);
      empty_q <= (lvl_d == '0);
      if (do_pop) dout_q <= mem_q[rptr_q[AW-1:0]];
    end
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a frame FSM.
// tx is registered one cycle behind the state that produces it.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BAUD_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int CW = cnt_w(BAUD_MAX);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_MAX - 1);

  uart_state_e state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q;
  logic          pop;
  logic          empty;
  logic          full;
  logic [7:0]    head;
  logic          baud_end;
  logic          in_frame;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .push     (pi_flag),
    .pop      (pop),
    .din      (pi_data),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);
  assign in_frame = (state_q == START) ||
                    (state_q == DATA) ||
                    (state_q == STOP);

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    if (in_frame && !baud_end) begin
      baud_d = baud_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = head;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= pi_flag & full;
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE);
  assign fifo_full = full;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit.
// A line monitor decodes frames into a queue with start cycles.
module tb_uart_tx_fifo;

  localparam int B = 10;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] pi_data = '0;
  logic       pi_flag = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;

  logic [9:0] mon_f[$];
  int         mon_t[$];

  uart_tx_fifo #(
    .UART_BPS  (100_000),
    .CLK_FREQ  (1_000_000),
    .FIFO_DEPTH(16)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
  end

  // Mid-bit sampling decoder, frame bit 0 = start bit.
  initial begin : mon
    logic [9:0] f;
    int t;
    f = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sys_rst_n === 1'b1 && tx === 1'b0) begin
        t = cyc;
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? B / 2 : B) begin
            @(posedge sys_clk);
            #1;
          end
          f[i] = tx;
        end
        mon_f.push_back(f);
        mon_t.push_back(t);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    pi_data = d;
    pi_flag = 1'b1;
    step();
    pi_flag = 1'b0;
  endtask

  task automatic get_frame(output logic [9:0] f, output int t);
    f = '0;
    t = 0;
    for (int k = 0; k < 300 && mon_f.size() == 0; k++) step();
    if (mon_f.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_timeout: got no frame, expected one");
    end else begin
      f = mon_f.pop_front();
      t = mon_t.pop_front();
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 300 && tx_busy !== 1'b0; k++) step();
    chk(nm, 32'(tx_busy), 32'd0);
  endtask

  vec_t tbl[6];
  logic [9:0] f0, f1, f2;
  int t0, t1, t2;
  int lat, n, lows, busys, ovf0;

  initial begin : main
    tbl[0] = '{8'h55, 10'b1_01010101_0};
    tbl[1] = '{8'h01, 10'b1_00000001_0};
    tbl[2] = '{8'h80, 10'b1_10000000_0};
    tbl[3] = '{8'hFF, 10'b1_11111111_0};
    tbl[4] = '{8'h00, 10'b1_00000000_0};
    tbl[5] = '{8'hA3, 10'b1_10100011_0};

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) step();

    foreach (tbl[v]) begin
      push(tbl[v].data);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        step();
        if (tx === 1'b0) begin
          lat = k;
          break;
        end
      end
      chk("latency", 32'(lat), 32'd3);
      get_frame(f0, t0);
      chk("frame", 32'(f0), 32'(tbl[v].frame));
      wait_idle("idle_after_vec");
      repeat (3) step();
    end

    // tx_busy spans LOAD + START + 8 DATA + STOP.
    push(8'h3C);
    chk("busy_at_push", 32'(tx_busy), 32'd0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (tx_busy === 1'b1) n++;
      else if (n > 0) break;
    end
    chk("busy_len", 32'(n), 32'(10 * B + 1));
    get_frame(f0, t0);
    chk("busy_frame", 32'(f0), 32'(10'b1_00111100_0));
    repeat (3) step();

    push(8'h01);
    push(8'h80);
    push(8'hFF);
    get_frame(f0, t0);
    get_frame(f1, t1);
    get_frame(f2, t2);
    chk("burst_f0", 32'(f0), 32'(10'b1_00000001_0));
    chk("burst_f1", 32'(f1), 32'(10'b1_10000000_0));
    chk("burst_f2", 32'(f2), 32'(10'b1_11111111_0));
    chk("stop_len01", 32'(t1 - t0 - 9 * B), 32'(B + 1));
    chk("stop_len12", 32'(t2 - t1 - 9 * B), 32'(B + 1));
    wait_idle("idle_after_burst");
    repeat (3) step();

    ovf0 = ovf_cnt;
    for (int i = 0; i < 18; i++) begin
      pi_data = 8'(8'h40 + i);
      pi_flag = 1'b1;
      step();
    end
    pi_flag = 1'b0;
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    step();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    for (int i = 0; i < 17; i++) begin
      get_frame(f0, t0);
      chk("ovf_frame", 32'(f0), 32'({1'b1, 8'(8'h40 + i), 1'b0}));
    end
    wait_idle("idle_after_ovf");
    repeat (5) step();
    chk("ovf_count", 32'(ovf_cnt - ovf0), 32'd1);
    chk("ovf_extra", 32'(mon_f.size()), 32'd0);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    get_frame(f0, t0);
    chk("rst_seq_f0", 32'(f0), 32'(10'b1_00010001_0));
    for (int k = 0; k < 50 && tx !== 1'b0; k++) step();
    repeat (4 * B) step();
    chk("busy_pre_rst", 32'(tx_busy), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_full", 32'(fifo_full), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (100) step();
    mon_f.delete();
    mon_t.delete();
    lows = 0;
    busys = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    chk("post_rst_tx_low", 32'(lows), 32'd0);
    chk("post_rst_busy", 32'(busys), 32'd0);
    chk("post_rst_frames", 32'(mon_f.size()), 32'd0);
    chk("post_rst_full", 32'(fifo_full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
